// File: rtl/hdmi_packet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_packet_pkg
// Purpose  : Shared types, constants and the BCH(64,56)/(32,24) step function
//            for the HDMI data-island packet path.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_packet_pkg;

    typedef logic [23:0] packet_header_t;
    typedef logic [55:0] subpacket_t;

    localparam logic [7:0] BCH_POLY_DEFAULT   = 8'h83;
    localparam int         PACKET_SLOT_CYCLES = 32;
    localparam int         HEADER_DATA_BITS   = 24;
    localparam int         SUB_DATA_BITS      = 56;

    // One right-shifting LFSR step of the BCH parity generator.
    function automatic logic [7:0] bch_step(input logic [7:0] ecc,
                                            input logic       d,
                                            input logic [7:0] poly);
        logic fb;
        fb = d ^ ecc[0];
        return (ecc >> 1) ^ (fb ? poly : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_island_packet_serializer_bch_ecc_lane.sv
`default_nettype none
// ============================================================================
// Module   : bch_ecc_lane
// Purpose  : One serial lane: emits data bits then its own BCH parity bits.
// Revision : 1.0 - initial release
// ============================================================================
module bch_ecc_lane
    import hdmi_packet_pkg::*;
#(
    parameter int         BITS_PER_CYCLE = 1,
    parameter int         DATA_BITS      = HEADER_DATA_BITS,
    parameter logic [7:0] POLY           = BCH_POLY_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic [4:0]                i_cycle,
    input  logic [DATA_BITS-1:0]      i_data,
    output logic [BITS_PER_CYCLE-1:0] o_bits
);

    localparam int         DATA_CYCLES   = DATA_BITS / BITS_PER_CYCLE;
    localparam logic [4:0] C_DATA_CYCLES = 5'(DATA_CYCLES);

    logic [7:0]  r_ecc;
    logic [7:0]  w_ecc_next;
    logic [63:0] w_data_ext;
    logic        w_is_data;

    always_comb begin
        w_data_ext = 64'(i_data);
        w_is_data  = (i_cycle < C_DATA_CYCLES);
        // Parity of the previous slot must never leak into cycle 0.
        w_ecc_next = (i_cycle == 5'd0) ? 8'h00 : r_ecc;
        o_bits     = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (w_is_data) begin
                o_bits[k]  = w_data_ext[6'(32'(i_cycle) * BITS_PER_CYCLE + k)];
                w_ecc_next = bch_step(w_ecc_next, o_bits[k], POLY);
            end else begin
                o_bits[k]  = r_ecc[3'((32'(i_cycle) - DATA_CYCLES) * BITS_PER_CYCLE + k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_ecc <= 8'h00;
        end else if (w_is_data) begin
            r_ecc <= w_ecc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_island_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module   : data_island_packet_serializer
// Purpose  : Shadows one HDMI packet and serialises it with BCH parity into
//            9-bit TERC4 symbols over a 32-cycle data-island slot.
// Revision : 1.0 - initial release
// ============================================================================
module data_island_packet_serializer
    import hdmi_packet_pkg::*;
#(
    parameter logic [7:0] BCH_POLY    = BCH_POLY_DEFAULT,
    parameter int         SLOT_CYCLES = PACKET_SLOT_CYCLES
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic             packet_load,
    output logic [8:0]       packet_data,
    output logic             slot_start
);

    generate
        if (SLOT_CYCLES != 32) begin : g_bad_slot_cycles
            $error("data_island_packet_serializer: SLOT_CYCLES must be 32");
        end
    endgenerate

    logic [4:0]       r_counter;
    packet_header_t   r_header;
    subpacket_t [3:0] r_sub;
    logic             w_hdr_bit;
    logic [1:0]       w_sub_bits [4];
    logic [8:0]       w_symbol;

    // Idle keeps the shadow transparent so the first slot sees the last idle inputs.
    assign packet_load = !reset && (!data_island_period || (r_counter == 5'd31));

    always_ff @(posedge clk_pixel) begin
        if (reset || !data_island_period) begin
            r_counter <= 5'd0;
        end else begin
            r_counter <= r_counter + 5'd1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_header <= '0;
            r_sub    <= '0;
        end else if (packet_load) begin
            r_header <= header;
            r_sub    <= sub;
        end
    end

    bch_ecc_lane #(
        .BITS_PER_CYCLE (1),
        .DATA_BITS      (HEADER_DATA_BITS),
        .POLY           (BCH_POLY)
    ) u_hdr_lane (
        .clk     (clk_pixel),
        .rst     (reset),
        .i_en    (data_island_period),
        .i_cycle (r_counter),
        .i_data  (r_header),
        .o_bits  (w_hdr_bit)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub_lane
            bch_ecc_lane #(
                .BITS_PER_CYCLE (2),
                .DATA_BITS      (SUB_DATA_BITS),
                .POLY           (BCH_POLY)
            ) u_sub_lane (
                .clk     (clk_pixel),
                .rst     (reset),
                .i_en    (data_island_period),
                .i_cycle (r_counter),
                .i_data  (r_sub[gi]),
                .o_bits  (w_sub_bits[gi])
            );
        end
    endgenerate

    always_comb begin
        w_symbol    = 9'd0;
        w_symbol[0] = w_hdr_bit;
        for (int i = 0; i < 4; i++) begin
            w_symbol[1 + i] = w_sub_bits[i][0];
            w_symbol[5 + i] = w_sub_bits[i][1];
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset || !data_island_period) begin
            packet_data <= 9'd0;
            slot_start  <= 1'b0;
        end else begin
            packet_data <= w_symbol;
            slot_start  <= (r_counter == 5'd0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_island_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_island_packet_serializer
// Purpose  : Directed self-checking bench with a bit-serial BCH golden model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_island_packet_serializer;

    typedef struct packed {
        logic [8:0] pd;
        logic       ss;
    } exp_t;

    logic             clk_pixel = 1'b0;
    logic             reset = 1'b1;
    logic             data_island_period = 1'b0;
    logic [23:0]      header = '0;
    logic [3:0][55:0] sub = '0;
    logic             packet_load;
    logic [8:0]       packet_data;
    logic             slot_start;

    int checks = 0;
    int errors = 0;

    exp_t             q[$];
    logic [4:0]       m_cnt = '0;
    logic [23:0]      m_hdr = '0;
    logic [3:0][55:0] m_sub = '0;

    always #5 clk_pixel = ~clk_pixel;

    data_island_packet_serializer dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
        .packet_load        (packet_load),
        .packet_data        (packet_data),
        .slot_start         (slot_start)
    );

    function automatic logic [7:0] ref_step(input logic [7:0] e, input logic d);
        logic fb;
        fb = d ^ e[0];
        return (e >> 1) ^ (fb ? 8'h83 : 8'h00);
    endfunction

    // Full-message parity computed bit-serially, then the symbol for slot cycle c.
    function automatic logic [8:0] gold(input int c, input logic [23:0] h,
                                        input logic [3:0][55:0] s);
        logic [7:0] eh;
        logic [7:0] es;
        logic [8:0] y;
        eh = 8'h00;
        for (int k = 0; k < 24; k++) eh = ref_step(eh, h[k]);
        if (c < 24) y[0] = h[c];
        else        y[0] = eh[c - 24];
        for (int i = 0; i < 4; i++) begin
            es = 8'h00;
            for (int k = 0; k < 56; k++) es = ref_step(es, s[i][k]);
            if (c < 28) begin
                y[1 + i] = s[i][2 * c];
                y[5 + i] = s[i][2 * c + 1];
            end else begin
                y[1 + i] = es[2 * (c - 28)];
                y[5 + i] = es[2 * (c - 28) + 1];
            end
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic tick(input logic d, input logic r, input logic [23:0] h,
                        input logic [3:0][55:0] s);
        exp_t e;
        logic ld;
        reset = r;
        data_island_period = d;
        header = h;
        sub = s;
        #1;
        ld = !r && (!d || m_cnt == 5'd31);
        chk("packet_load", {8'd0, packet_load}, {8'd0, ld});
        if (r || !d) e = '{pd: 9'd0, ss: 1'b0};
        else         e = '{pd: gold(int'(m_cnt), m_hdr, m_sub), ss: (m_cnt == 5'd0)};
        q.push_back(e);
        if (r) begin
            m_hdr = '0;
            m_sub = '0;
            m_cnt = '0;
        end else begin
            if (ld) begin
                m_hdr = h;
                m_sub = s;
            end
            m_cnt = d ? m_cnt + 5'd1 : 5'd0;
        end
        @(posedge clk_pixel);
        #1;
        e = q.pop_front();
        chk("packet_data", packet_data, e.pd);
        chk("slot_start", {8'd0, slot_start}, {8'd0, e.ss});
    endtask

    task automatic run_slot(input logic [23:0] h, input logic [3:0][55:0] s);
        for (int c = 0; c < 32; c++) tick(1'b1, 1'b0, h, s);
    endtask

    logic [23:0]      hA, hB, hC;
    logic [3:0][55:0] sA, sB, sC, sZ;

    initial begin
        sZ = '0;
        @(posedge clk_pixel);
        #1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 24'h0, sZ);
        tick(1'b0, 1'b0, 24'h0, sZ);
        tick(1'b0, 1'b0, 24'h0, sZ);

        // All-zero packet.
        run_slot(24'h0, sZ);
        tick(1'b0, 1'b0, 24'h000001, sZ);

        // Single header bit.
        run_slot(24'h000001, sZ);
        sA = '0;
        sA[0] = 56'h0000_0000_2812_35;
        tick(1'b0, 1'b0, 24'h0D0282, sA);

        // AVI-like header with checksum-consistent PB bytes in sub0.
        run_slot(24'h0D0282, sA);

        // Back-to-back slots with mid-slot input changes.
        hA = 24'hA5_5A_C3;
        hB = 24'h12_34_56;
        hC = 24'hFF_00_FF;
        for (int i = 0; i < 4; i++) begin
            sA[i] = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
            sB[i] = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
            sC[i] = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
        end
        tick(1'b0, 1'b0, hA, sA);
        for (int c = 0; c < 32; c++) begin
            if (c < 10) tick(1'b1, 1'b0, hA, sA);
            else        tick(1'b1, 1'b0, hB, sB);
        end
        for (int c = 0; c < 32; c++) begin
            if (c < 10) tick(1'b1, 1'b0, hB, sB);
            else        tick(1'b1, 1'b0, hC, sC);
        end
        tick(1'b0, 1'b0, hC, sC);

        // Abandon at counter 17, idle 3 cycles, then a fresh slot.
        for (int c = 0; c < 17; c++) tick(1'b1, 1'b0, hC, sC);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, hA, sA);
        run_slot(hA, sA);

        // Reset at counter 20, then a clean restart.
        tick(1'b0, 1'b0, hB, sB);
        for (int c = 0; c < 20; c++) tick(1'b1, 1'b0, hB, sB);
        tick(1'b1, 1'b1, hB, sB);
        run_slot(hC, sC);
        run_slot(hA, sA);
        tick(1'b0, 1'b0, hA, sA);
        tick(1'b0, 1'b0, hA, sA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
